// File: rtl/cv32e40p_if_id_queue.sv
// ----------------------------------------------------------------------------
// cv32e40p_if_id_queue
//
// IF->ID decoupling queue. It holds up to DEPTH decompressed instructions,
// together with their PC and decoder flags, between the aligner and the ID
// stage. This replaces the single-entry IF/ID pipeline register.
//
// Behaviour summary:
//   - The head entry is read from registered storage. There is no bypass, so a
//     push into an empty queue becomes visible at the head one cycle later.
//   - A full queue still accepts a push in a cycle where it also pops.
//   - flush_i empties the queue in one cycle. It drops any same-cycle push and
//     ignores any same-cycle pop. Storage contents are left untouched.
//   - When PARITY_EN is set, each entry stores even parity over its fields.
//     A mismatch at the valid head raises parity_err_o, and err_sticky_o then
//     latches the error until reset. The entry is still delivered; the ID
//     stage decides what to do with it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush_i               drop all entries (pc_set | clear_instr_valid)
//   fetch_valid_i         aligner presents an instruction
//   fetch_ready_o         queue accepts a push this cycle
//   instr_i, pc_i         decompressed instruction and its PC
//   is_compressed_i       compressed flag
//   illegal_c_i           illegal compressed flag
//   id_ready_i            ID stage can take the head entry
//   halt_if_i             freeze popping
//   instr_valid_id_o      head entry valid
//   instr_rdata_id_o      head instruction
//   pc_id_o               head PC
//   is_compressed_id_o    head compressed flag
//   illegal_c_insn_id_o   head illegal flag
//   occupancy_o           number of entries held (0..DEPTH)
//   parity_err_o          head parity mismatch (valid-qualified)
//   err_sticky_o          sticky parity error, cleared only by reset
// ----------------------------------------------------------------------------
module cv32e40p_if_id_queue #(
    parameter int unsigned DEPTH     = 2,     // power of two, >= 2
    parameter bit          PARITY_EN = 1'b1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          fetch_valid_i,
    output logic          fetch_ready_o,
    input  logic [31:0]   instr_i,
    input  logic [31:0]   pc_i,
    input  logic          is_compressed_i,
    input  logic          illegal_c_i,
    input  logic          id_ready_i,
    input  logic          halt_if_i,
    output logic          instr_valid_id_o,
    output logic [31:0]   instr_rdata_id_o,
    output logic [31:0]   pc_id_o,
    output logic          is_compressed_id_o,
    output logic          illegal_c_insn_id_o,
    output logic [AW:0]   occupancy_o,
    output logic          parity_err_o,
    output logic          err_sticky_o
);

    localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

    // Entry storage, one packed vector per field
    logic [DEPTH-1:0][31:0] r_instr_mem;
    logic [DEPTH-1:0][31:0] r_pc_mem;
    logic [DEPTH-1:0]       r_c_mem;
    logic [DEPTH-1:0]       r_ill_mem;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_parity_err;
    logic w_err_sticky;

    assign w_full           = (r_count == LP_FULL);
    assign instr_valid_id_o = (r_count != '0);
    assign w_pop            = instr_valid_id_o & id_ready_i & ~halt_if_i;
    // A same-cycle pop frees a slot, so a full queue can still accept a push.
    assign fetch_ready_o    = ~flush_i & (~w_full | w_pop);
    assign w_push           = fetch_valid_i & fetch_ready_o;

    // Pointers and count. Pointers are AW bits wide, so they wrap at DEPTH
    // without any extra logic.
    // NOTE: sequential state uses non-blocking assignments only, so every
    //       flop samples its inputs from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write. flush_i already blocks w_push through fetch_ready_o.
    // NOTE: the storage is deliberately cleared on reset so the head fields
    //       read as zero out of reset. This costs a reset net on every
    //       storage flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_mem <= '0;
            r_pc_mem    <= '0;
            r_c_mem     <= '0;
            r_ill_mem   <= '0;
        end else if (w_push) begin
            r_instr_mem[r_wr_ptr] <= instr_i;
            r_pc_mem[r_wr_ptr]    <= pc_i;
            r_c_mem[r_wr_ptr]     <= is_compressed_i;
            r_ill_mem[r_wr_ptr]   <= illegal_c_i;
        end
    end

    assign instr_rdata_id_o    = r_instr_mem[r_rd_ptr];
    assign pc_id_o             = r_pc_mem[r_rd_ptr];
    assign is_compressed_id_o  = r_c_mem[r_rd_ptr];
    assign illegal_c_insn_id_o = r_ill_mem[r_rd_ptr];
    assign occupancy_o         = r_count;

    generate
        if (PARITY_EN) begin : g_parity
            logic [DEPTH-1:0] r_par_mem;
            logic             r_err_sticky;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_par_mem <= '0;
                end else if (w_push) begin
                    r_par_mem[r_wr_ptr] <= ^{instr_i, pc_i, is_compressed_i, illegal_c_i};
                end
            end

            // The parity is recomputed over the head fields as they sit in
            // storage, so any corruption after the write shows up here.
            assign w_parity_err = instr_valid_id_o &
                                  (r_par_mem[r_rd_ptr] !=
                                   ^{instr_rdata_id_o, pc_id_o,
                                     is_compressed_id_o, illegal_c_insn_id_o});

            // Sticky on purpose: a flush does not clear it, only reset does.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_err_sticky <= 1'b0;
                end else if (w_parity_err) begin
                    r_err_sticky <= 1'b1;
                end
            end

            assign w_err_sticky = r_err_sticky;
        end else begin : g_no_parity
            assign w_parity_err = 1'b0;
            assign w_err_sticky = 1'b0;
        end
    endgenerate

    assign parity_err_o = w_parity_err;
    assign err_sticky_o = w_err_sticky;

endmodule

// File: tb/tb_cv32e40p_if_id_queue.sv
// ----------------------------------------------------------------------------
// Testbench for cv32e40p_if_id_queue.
//
// Two instances are used:
//   dut_a  DEPTH=2, parity enabled
//   dut_b  DEPTH=4, parity disabled
//
// For each instance, a negedge monitor keeps a scoreboard queue of the
// entries pushed. It compares each popped head against the front of that
// queue, and it also checks occupancy and valid against the queue size.
// The scenario tasks add their own targeted checks, sampled #1 after the
// rising edge.
// ----------------------------------------------------------------------------
module tb_cv32e40p_if_id_queue;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- instance A: DEPTH=2, parity on ----------------
    logic        a_flush, a_fv, a_c, a_ill, a_idr, a_halt;
    logic [31:0] a_instr, a_pc;
    logic        a_rdy, a_vld, a_cid, a_illid, a_perr, a_sticky;
    logic [31:0] a_rdata, a_pcid;
    logic [1:0]  a_occ;

    cv32e40p_if_id_queue #(.DEPTH(2), .PARITY_EN(1'b1)) dut_a (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush_i             (a_flush),
        .fetch_valid_i       (a_fv),
        .fetch_ready_o       (a_rdy),
        .instr_i             (a_instr),
        .pc_i                (a_pc),
        .is_compressed_i     (a_c),
        .illegal_c_i         (a_ill),
        .id_ready_i          (a_idr),
        .halt_if_i           (a_halt),
        .instr_valid_id_o    (a_vld),
        .instr_rdata_id_o    (a_rdata),
        .pc_id_o             (a_pcid),
        .is_compressed_id_o  (a_cid),
        .illegal_c_insn_id_o (a_illid),
        .occupancy_o         (a_occ),
        .parity_err_o        (a_perr),
        .err_sticky_o        (a_sticky)
    );

    // ---------------- instance B: DEPTH=4, parity off ----------------
    logic        b_flush, b_fv, b_c, b_ill, b_idr, b_halt;
    logic [31:0] b_instr, b_pc;
    logic        b_rdy, b_vld, b_cid, b_illid, b_perr, b_sticky;
    logic [31:0] b_rdata, b_pcid;
    logic [2:0]  b_occ;

    cv32e40p_if_id_queue #(.DEPTH(4), .PARITY_EN(1'b0)) dut_b (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush_i             (b_flush),
        .fetch_valid_i       (b_fv),
        .fetch_ready_o       (b_rdy),
        .instr_i             (b_instr),
        .pc_i                (b_pc),
        .is_compressed_i     (b_c),
        .illegal_c_i         (b_ill),
        .id_ready_i          (b_idr),
        .halt_if_i           (b_halt),
        .instr_valid_id_o    (b_vld),
        .instr_rdata_id_o    (b_rdata),
        .pc_id_o             (b_pcid),
        .is_compressed_id_o  (b_cid),
        .illegal_c_insn_id_o (b_illid),
        .occupancy_o         (b_occ),
        .parity_err_o        (b_perr),
        .err_sticky_o        (b_sticky)
    );

    // ---------------- scoreboards ----------------
    logic [65:0] qa[$];
    logic [65:0] qb[$];
    int          b_pops = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            logic [65:0] exp_e;
            checks++;
            if (a_occ !== 2'(qa.size()) || a_vld !== (qa.size() != 0)) begin
                errors++;
                $display("FAIL a_occ_vld got occ=%0d vld=%b exp occ=%0d", a_occ, a_vld, qa.size());
            end
            if (a_flush) begin
                qa.delete();
            end else begin
                if (a_vld && a_idr && !a_halt && qa.size() != 0) begin
                    exp_e = qa.pop_front();
                    checks++;
                    if ({a_rdata, a_pcid, a_cid, a_illid} !== exp_e) begin
                        errors++;
                        $display("FAIL a_pop got=%h/%h/%b%b exp=%h/%h/%b%b", a_rdata, a_pcid, a_cid,
                                 a_illid, exp_e[65:34], exp_e[33:2], exp_e[1], exp_e[0]);
                    end
                end
                if (a_fv && a_rdy) qa.push_back({a_instr, a_pc, a_c, a_ill});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [65:0] exp_e;
            checks++;
            if (b_occ !== 3'(qb.size()) || b_vld !== (qb.size() != 0) || b_occ > 3'd4) begin
                errors++;
                $display("FAIL b_occ_vld got occ=%0d vld=%b exp occ=%0d", b_occ, b_vld, qb.size());
            end
            checks++;
            if (b_perr !== 1'b0 || b_sticky !== 1'b0) begin
                errors++;
                $display("FAIL b_parity_tied got perr=%b sticky=%b exp 0/0", b_perr, b_sticky);
            end
            if (b_flush) begin
                qb.delete();
            end else begin
                if (b_vld && b_idr && !b_halt && qb.size() != 0) begin
                    exp_e = qb.pop_front();
                    b_pops++;
                    checks++;
                    if ({b_rdata, b_pcid, b_cid, b_illid} !== exp_e) begin
                        errors++;
                        $display("FAIL b_pop got=%h/%h exp=%h/%h", b_rdata, b_pcid,
                                 exp_e[65:34], exp_e[33:2]);
                    end
                end
                if (b_fv && b_rdy) qb.push_back({b_instr, b_pc, b_c, b_ill});
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                           input logic idr, input logic halt, input logic fl);
        a_fv = fv; a_instr = ins; a_pc = pc; a_c = ins[0]; a_ill = ins[1];
        a_idr = idr; a_halt = halt; a_flush = fl;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        a_drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        b_flush = 0; b_fv = 0; b_instr = 0; b_pc = 0; b_c = 0; b_ill = 0; b_idr = 0; b_halt = 0;
        #2;
        checks++;
        if (a_rdy !== 1'b1 || a_vld !== 1'b0 || a_occ !== 2'd0 || a_perr !== 1'b0 ||
            a_sticky !== 1'b0 || a_rdata !== 32'h0 || a_pcid !== 32'h0) begin
            errors++;
            $display("FAIL reset_a got rdy=%b vld=%b occ=%0d perr=%b sticky=%b rdata=%h pc=%h exp 1/0/0/0/0/0/0",
                     a_rdy, a_vld, a_occ, a_perr, a_sticky, a_rdata, a_pcid);
        end
        checks++;
        if (b_rdy !== 1'b1 || b_vld !== 1'b0 || b_occ !== 3'd0) begin
            errors++;
            $display("FAIL reset_b got rdy=%b vld=%b occ=%0d exp 1/0/0", b_rdy, b_vld, b_occ);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        a_drive(1'b1, 32'h00A00093, 32'h80, 1'b0, 1'b0, 1'b0);
        tick();
        a_drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (a_vld !== 1'b1 || a_rdata !== 32'h00A00093 || a_pcid !== 32'h80 || a_occ !== 2'd1) begin
            errors++;
            $display("FAIL single got vld=%b rdata=%h pc=%h occ=%0d exp 1/00a00093/80/1",
                     a_vld, a_rdata, a_pcid, a_occ);
        end
        a_idr = 1'b1;
        tick();
        a_idr = 1'b0;
        checks++;
        if (a_vld !== 1'b0 || a_occ !== 2'd0) begin
            errors++;
            $display("FAIL single_pop got vld=%b occ=%0d exp 0/0", a_vld, a_occ);
        end
    endtask

    task automatic test_full();
        a_drive(1'b1, 32'h11111111, 32'h100, 1'b0, 1'b0, 1'b0);
        tick();
        a_drive(1'b1, 32'h22222222, 32'h104, 1'b0, 1'b0, 1'b0);
        tick();
        a_drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (a_occ !== 2'd2 || a_rdy !== 1'b0) begin
            errors++;
            $display("FAIL full got occ=%0d rdy=%b exp 2/0", a_occ, a_rdy);
        end
        a_drive(1'b1, 32'h33333333, 32'h108, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (a_rdy !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_ready got rdy=%b exp 1", a_rdy);
        end
        tick();
        a_drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (a_occ !== 2'd2 || a_rdata !== 32'h22222222) begin
            errors++;
            $display("FAIL full_pushpop got occ=%0d head=%h exp 2/22222222", a_occ, a_rdata);
        end
        tick();
        checks++;
        if (a_occ !== 2'd1 || a_rdata !== 32'h33333333) begin
            errors++;
            $display("FAIL full_drain got occ=%0d head=%h exp 1/33333333", a_occ, a_rdata);
        end
        tick();
        a_idr = 1'b0;
    endtask

    task automatic test_halt();
        a_drive(1'b1, 32'h44444444, 32'h200, 1'b0, 1'b0, 1'b0);
        tick();
        a_drive(1'b1, 32'h55555555, 32'h204, 1'b0, 1'b0, 1'b0);
        tick();
        a_drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if (a_rdy !== 1'b0) begin
            errors++;
            $display("FAIL halt_ready got rdy=%b exp 0", a_rdy);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (a_occ !== 2'd2 || a_rdata !== 32'h44444444 || a_pcid !== 32'h200) begin
                errors++;
                $display("FAIL halt_hold got occ=%0d head=%h pc=%h exp 2/44444444/200", a_occ, a_rdata, a_pcid);
            end
        end
        a_halt = 1'b0;
        tick();
        checks++;
        if (a_occ !== 2'd1 || a_rdata !== 32'h55555555) begin
            errors++;
            $display("FAIL halt_release got occ=%0d head=%h exp 1/55555555", a_occ, a_rdata);
        end
        tick();
        a_idr = 1'b0;
    endtask

    task automatic test_flush();
        a_drive(1'b1, 32'h66666666, 32'h300, 1'b0, 1'b0, 1'b0);
        tick();
        a_drive(1'b1, 32'h77777777, 32'h304, 1'b0, 1'b0, 1'b0);
        tick();
        a_drive(1'b1, 32'hDEADBEEF, 32'h308, 1'b1, 1'b0, 1'b1);
        #1;
        checks++;
        if (a_rdy !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got rdy=%b exp 0", a_rdy);
        end
        tick();
        a_drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (a_vld !== 1'b0 || a_occ !== 2'd0) begin
            errors++;
            $display("FAIL flush_empty got vld=%b occ=%0d exp 0/0", a_vld, a_occ);
        end
        a_drive(1'b1, 32'h88888888, 32'h400, 1'b0, 1'b0, 1'b0);
        tick();
        a_drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (a_occ !== 2'd1 || a_rdata !== 32'h88888888 || a_pcid !== 32'h400) begin
            errors++;
            $display("FAIL flush_dropped got occ=%0d head=%h pc=%h exp 1/88888888/400", a_occ, a_rdata, a_pcid);
        end
        a_idr = 1'b1;
        tick();
        a_idr = 1'b0;
    endtask

    task automatic test_parity();
        logic [1:0][31:0] v_mem;
        a_drive(1'b1, 32'h00A00093, 32'h500, 1'b0, 1'b0, 1'b0);
        tick();
        a_drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (a_perr !== 1'b0 || a_sticky !== 1'b0) begin
            errors++;
            $display("FAIL parity_clean got perr=%b sticky=%b exp 0/0", a_perr, a_sticky);
        end
        // Flip bit 5 in every stored word, so the head is corrupted wherever it sits.
        v_mem = dut_a.r_instr_mem;
        v_mem[0][5] = ~v_mem[0][5];
        v_mem[1][5] = ~v_mem[1][5];
        force dut_a.r_instr_mem = v_mem;
        #1;
        checks++;
        if (a_perr !== 1'b1 || a_rdata !== 32'h00A000B3) begin
            errors++;
            $display("FAIL parity_detect got perr=%b head=%h exp 1/00a000b3", a_perr, a_rdata);
        end
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        tick();
        release dut_a.r_instr_mem;
        checks++;
        if (a_vld !== 1'b0 || a_perr !== 1'b0 || a_sticky !== 1'b1) begin
            errors++;
            $display("FAIL parity_sticky got vld=%b perr=%b sticky=%b exp 0/0/1", a_vld, a_perr, a_sticky);
        end
    endtask

    task automatic test_wrap();
        int pushed = 0;
        int cyc = 0;
        b_fv = 0; b_idr = 0; b_halt = 0; b_flush = 0;
        while ((pushed < 10 || qb.size() != 0) && cyc < 400) begin
            b_fv    = (pushed < 10) && ($urandom_range(3) != 0);
            b_instr = $urandom;
            b_pc    = 32'h1000 + 32'(pushed * 4);
            b_c     = b_instr[0];
            b_ill   = b_instr[1];
            b_idr   = ($urandom_range(2) != 0);
            b_halt  = ($urandom_range(4) == 0);
            // Hold ID off for the first cycles so the queue fills up and the pointers wrap.
            if (cyc < 6) b_idr = 1'b0;
            #1;
            if (b_fv && b_rdy) pushed++;
            tick();
            cyc++;
        end
        b_fv = 0; b_idr = 0; b_halt = 0;
        checks++;
        if (pushed != 10 || b_pops != 10 || qb.size() != 0) begin
            errors++;
            $display("FAIL wrap_complete got pushed=%0d popped=%0d left=%0d exp 10/10/0", pushed, b_pops, qb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_full();
        test_halt();
        test_flush();
        test_parity();
        test_wrap();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
